// File: rtl/video_in_pkg.sv
// rtl/video_in_pkg.sv - shared types and default geometry for the video input path
package video_in_pkg;

  localparam int DEF_P_WIDTH    = 640;
  localparam int DEF_P_HEIGHT   = 480;
  localparam int DEF_FIFO_DEPTH = 64;
  localparam int DEF_NB_PACK    = 16;

  localparam int COL_W  = 10;
  localparam int LINE_W = 9;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    WAIT_LINE  = 2'd1,
    IN_LINE    = 2'd2
  } state_e;

endpackage

// File: rtl/video_in_fifo.sv
// rtl/video_in_fifo.sv - synchronous 32-bit word FIFO with registered read data and count
module video_in_fifo #(
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       nRST,
  input  logic                       wr_en,
  input  logic [31:0]                wr_data,
  input  logic                       rd_en,
  output logic [31:0]                rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic          do_wr, do_rd;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rd_data = rd_data_q;

  // Pointer/count bookkeeping; a write on a full FIFO only lands if a read frees the slot
  always_comb begin
    do_rd     = rd_en && !empty;
    do_wr     = wr_en && (!full || do_rd);
    wr_ptr_d  = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    rd_data_d = do_rd ? mem_q[rd_ptr_q] : rd_data_q;
    count_d   = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Word storage; contents need no reset because the count gates every read
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  // Control state register
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule

// File: rtl/video_in_pack.sv
// rtl/video_in_pack.sv - camera frame/line capture, 4-pixel packing and FIFO staging
module video_in_pack
  import video_in_pkg::*;
#(
  parameter int P_WIDTH    = DEF_P_WIDTH,
  parameter int P_HEIGHT   = DEF_P_HEIGHT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int NB_PACK    = DEF_NB_PACK
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        frame_valid,
  input  logic        line_valid,
  input  logic [7:0]  pixel_in,
  input  logic        rd_en,
  output logic [31:0] data_fifo,
  output logic        nb_pack_available,
  output logic        frame_start,
  output logic        overflow,
  output logic        sync_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [COL_W-1:0]  WIDTH_C = COL_W'(P_WIDTH);
  localparam logic [LINE_W-1:0] LINES_C = LINE_W'(P_HEIGHT);

  state_e             state_q, state_d;
  logic               fv_prev_q, fv_prev_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [31:0]        pack_q, pack_d;
  logic               wr_en_q, wr_en_d;
  logic [31:0]        wr_data_q, wr_data_d;
  logic               frame_start_q, frame_start_d;
  logic               overflow_q, overflow_d;
  logic               sync_err_q, sync_err_d;
  logic               capture, drop;
  logic [CW-1:0]      fifo_count;
  logic               fifo_full, fifo_empty;

  video_in_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .nRST    (nRST),
    .wr_en   (wr_en_q),
    .wr_data (wr_data_q),
    .rd_en   (rd_en),
    .rd_data (data_fifo),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign nb_pack_available = (fifo_count >= CW'(NB_PACK));
  assign frame_start       = frame_start_q;
  assign overflow          = overflow_q;
  assign sync_err          = sync_err_q;

  // Frame/line FSM, pixel packing and sticky error tracking
  always_comb begin
    state_d       = state_q;
    fv_prev_d     = frame_valid;
    col_d         = col_q;
    line_d        = line_q;
    pack_d        = pack_q;
    wr_en_d       = 1'b0;
    wr_data_d     = wr_data_q;
    frame_start_d = 1'b0;
    overflow_d    = overflow_q;
    sync_err_d    = sync_err_q;
    capture       = 1'b0;

    case (state_q)
      WAIT_FRAME: begin
        if (frame_valid && !fv_prev_q) begin
          state_d       = WAIT_LINE;
          frame_start_d = 1'b1;
          col_d         = '0;
          line_d        = '0;
          pack_d        = '0;
          overflow_d    = 1'b0;
          sync_err_d    = 1'b0;
        end
      end
      WAIT_LINE: begin
        if (!frame_valid) begin
          state_d = WAIT_FRAME;
          if (line_q != LINES_C) sync_err_d = 1'b1;
        end else if (line_valid) begin
          state_d = IN_LINE;
          capture = 1'b1;
        end
      end
      IN_LINE: begin
        if (line_valid) begin
          capture = 1'b1;
        end else begin
          // Line closed: any partial word is thrown away
          state_d = WAIT_LINE;
          if (col_q != WIDTH_C || col_q[1:0] != 2'd0) sync_err_d = 1'b1;
          col_d   = '0;
          pack_d  = '0;
          line_d  = line_q + LINE_W'(1);
        end
      end
      default: state_d = WAIT_FRAME;
    endcase

    if (capture) begin
      pack_d[{col_q[1:0], 3'b000} +: 8] = pixel_in;
      col_d = col_q + COL_W'(1);
      if (col_q[1:0] == 2'd3) begin
        wr_en_d   = 1'b1;
        wr_data_d = {pixel_in, pack_q[23:0]};
        pack_d    = '0;
      end
    end

    // A staged word is lost only when the FIFO is full and no read frees a slot
    drop = wr_en_q && fifo_full && !(rd_en && !fifo_empty);
    if (drop) overflow_d = 1'b1;
  end

  // State register; frame_valid history resets high so a frame already in flight is ignored
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q       <= WAIT_FRAME;
      fv_prev_q     <= 1'b1;
      col_q         <= '0;
      line_q        <= '0;
      pack_q        <= '0;
      wr_en_q       <= 1'b0;
      wr_data_q     <= '0;
      frame_start_q <= 1'b0;
      overflow_q    <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      fv_prev_q     <= fv_prev_d;
      col_q         <= col_d;
      line_q        <= line_d;
      pack_q        <= pack_d;
      wr_en_q       <= wr_en_d;
      wr_data_q     <= wr_data_d;
      frame_start_q <= frame_start_d;
      overflow_q    <= overflow_d;
      sync_err_q    <= sync_err_d;
    end
  end

endmodule

// File: tb/tb_video_in_pack.sv
// tb/tb_video_in_pack.sv - directed self-checking bench for video_in_pack
module tb_video_in_pack;
  import video_in_pkg::*;

  localparam int W  = 32;
  localparam int H  = 4;
  localparam int D  = 64;
  localparam int NB = 16;

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic        frame_valid = 1'b0;
  logic        line_valid = 1'b0;
  logic [7:0]  pixel_in = 8'h00;
  logic        rd_en = 1'b0;
  logic [31:0] data_fifo;
  logic        nb_pack_available;
  logic        frame_start;
  logic        overflow;
  logic        sync_err;

  video_in_pack #(
    .P_WIDTH    (W),
    .P_HEIGHT   (H),
    .FIFO_DEPTH (D),
    .NB_PACK    (NB)
  ) dut (
    .clk               (clk),
    .nRST              (nRST),
    .frame_valid       (frame_valid),
    .line_valid        (line_valid),
    .pixel_in          (pixel_in),
    .rd_en             (rd_en),
    .data_fifo         (data_fifo),
    .nb_pack_available (nb_pack_available),
    .frame_start       (frame_start),
    .overflow          (overflow),
    .sync_err          (sync_err)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail = 0;
  int          fs_cnt = 0;
  int          words_read = 0;
  logic [31:0] mq[$];
  logic [31:0] last_rd = 32'h0;
  bit          acc = 1'b0;
  bit          wp_v = 1'b0;
  logic [31:0] wp_d = 32'h0;
  logic [31:0] pk = 32'h0;
  int          mcol = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock with the current inputs; the queue model tracks what the FIFO must hold
  task automatic step(input bit cap);
    bit          do_rd;
    bit          do_wr;
    logic [31:0] e;
    do_rd = rd_en && (mq.size() > 0);
    do_wr = wp_v && (mq.size() < D || do_rd);
    @(posedge clk);
    #1;
    if (frame_start) fs_cnt++;
    if (do_rd) begin
      e = mq.pop_front();
      check("rd_data", data_fifo, e);
      last_rd = e;
      words_read++;
    end
    if (do_wr) mq.push_back(wp_d);
    wp_v = 1'b0;
    if (cap) begin
      pk[8*(mcol%4) +: 8] = pixel_in;
      mcol++;
      if (mcol % 4 == 0) begin
        wp_v = 1'b1;
        wp_d = pk;
      end
    end
  endtask

  function automatic logic rd_sel(input int mode);
    if (mode == 1) return wp_v;
    if (mode == 2) return nb_pack_available;
    return 1'b0;
  endfunction

  task automatic send_line(input int n, input int base, input int mode);
    mcol = 0;
    pk = 32'h0;
    for (int i = 0; i < n; i++) begin
      pixel_in = 8'(base + i);
      line_valid = 1'b1;
      rd_en = rd_sel(mode);
      step(acc);
    end
    line_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rd_en = rd_sel(mode);
      step(1'b0);
    end
    rd_en = 1'b0;
  endtask

  task automatic frame_rise();
    frame_valid = 1'b1;
    acc = 1'b1;
    step(1'b0);
  endtask

  task automatic frame_end();
    frame_valid = 1'b0;
    acc = 1'b0;
    step(1'b0);
    step(1'b0);
  endtask

  task automatic drain();
    rd_en = 1'b1;
    while (mq.size() > 0) step(1'b0);
    rd_en = 1'b0;
    step(1'b0);
  endtask

  task automatic full_frame(input int base, input int mode);
    frame_rise();
    for (int l = 0; l < H; l++) send_line(W, base + l * W, mode);
    frame_end();
  endtask

  initial begin
    // Reset state
    repeat (2) step(1'b0);
    check("rst_data_fifo", data_fifo, 32'h0);
    check("rst_nb_pack", 32'(nb_pack_available), 32'h0);
    check("rst_frame_start", 32'(frame_start), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    check("rst_sync_err", 32'(sync_err), 32'h0);
    check("rst_state", 32'(dut.state_q), 32'(WAIT_FRAME));
    nRST = 1'b1;

    // Frame already running when reset releases: nothing captured
    frame_valid = 1'b1;
    line_valid = 1'b1;
    pixel_in = 8'hAA;
    repeat (8) step(1'b0);
    check("partial_frame_count", 32'(dut.u_fifo.count_q), 32'd0);
    check("partial_frame_state", 32'(dut.state_q), 32'(WAIT_FRAME));
    line_valid = 1'b0;
    frame_valid = 1'b0;
    repeat (2) step(1'b0);

    // Read while empty is ignored
    rd_en = 1'b1;
    step(1'b0);
    rd_en = 1'b0;
    check("empty_rd_data", data_fifo, 32'h0);
    check("empty_rd_count", 32'(dut.u_fifo.count_q), 32'd0);

    // Basic packing: 01 02 03 04 -> 0x04030201
    fs_cnt = 0;
    frame_rise();
    check("frame_start_pulse", 32'(frame_start), 32'd1);
    step(1'b0);
    check("frame_start_one_cycle", 32'(frame_start), 32'd0);
    send_line(W, 1, 0);
    check("basic_count", 32'(dut.u_fifo.count_q), 32'd8);
    check("basic_nb_pack_low", 32'(nb_pack_available), 32'd0);
    check("basic_before_read", data_fifo, 32'h0);
    rd_en = 1'b1;
    step(1'b0);
    rd_en = 1'b0;
    check("basic_first_word", data_fifo, 32'h04030201);
    for (int l = 1; l < H; l++) send_line(W, 1 + l * W, 0);
    frame_end();
    check("basic_sync_err", 32'(sync_err), 32'd0);
    drain();

    // Complete frame, reading whenever enough words are stored
    fs_cnt = 0;
    words_read = 0;
    full_frame(8'h40, 2);
    drain();
    check("frame_words_read", 32'(words_read), 32'(W * H / 4));
    check("frame_start_count", 32'(fs_cnt), 32'd1);
    check("frame_overflow", 32'(overflow), 32'd0);
    check("frame_sync_err", 32'(sync_err), 32'd0);

    // Fill to 64 words, then push more with no reads
    full_frame(8'h10, 0);
    full_frame(8'h90, 0);
    check("fill_count", 32'(dut.u_fifo.count_q), 32'd64);
    check("fill_nb_pack", 32'(nb_pack_available), 32'd1);
    check("fill_no_overflow", 32'(overflow), 32'd0);
    frame_rise();
    send_line(W, 8'hC0, 0);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count", 32'(dut.u_fifo.count_q), 32'd64);
    frame_end();
    check("short_frame_sync_err", 32'(sync_err), 32'd1);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Full FIFO with write and read in the same cycle
    frame_rise();
    check("ovf_cleared_by_start", 32'(overflow), 32'd0);
    check("sync_cleared_by_start", 32'(sync_err), 32'd0);
    send_line(W, 8'hE0, 1);
    check("simul_count", 32'(dut.u_fifo.count_q), 32'd64);
    check("simul_no_overflow", 32'(overflow), 32'd0);
    frame_end();
    drain();
    rd_en = 1'b1;
    step(1'b0);
    rd_en = 1'b0;
    check("empty_hold_data", data_fifo, last_rd);
    check("empty_after_drain", 32'(dut.u_fifo.count_q), 32'd0);

    // Short line: partial word dropped, sync_err until next frame_start
    frame_rise();
    send_line(W - 2, 8'h20, 0);
    check("short_line_sync_err", 32'(sync_err), 32'd1);
    check("short_line_count", 32'(dut.u_fifo.count_q), 32'd7);
    for (int l = 1; l < H; l++) send_line(W, 8'h20 + l * W, 0);
    frame_end();
    check("short_line_sticky", 32'(sync_err), 32'd1);
    drain();
    frame_rise();
    check("sync_err_cleared", 32'(sync_err), 32'd0);
    for (int l = 0; l < H; l++) send_line(W, 8'h30 + l * W, 0);
    frame_end();
    check("clean_frame_sync_err", 32'(sync_err), 32'd0);
    drain();

    // Reset in the middle of a line
    frame_rise();
    mcol = 0;
    pk = 32'h0;
    for (int i = 0; i < 10; i++) begin
      pixel_in = 8'(8'h50 + i);
      line_valid = 1'b1;
      step(acc);
    end
    check("pre_reset_count", 32'(dut.u_fifo.count_q), 32'd2);
    nRST = 1'b0;
    #3;
    check("async_reset_count", 32'(dut.u_fifo.count_q), 32'd0);
    check("async_reset_state", 32'(dut.state_q), 32'(WAIT_FRAME));
    nRST = 1'b1;
    mq.delete();
    wp_v = 1'b0;
    acc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pixel_in = 8'(8'h60 + i);
      step(1'b0);
    end
    check("post_reset_no_write", 32'(dut.u_fifo.count_q), 32'd0);
    line_valid = 1'b0;
    frame_valid = 1'b0;
    repeat (2) step(1'b0);
    full_frame(8'h70, 0);
    check("resume_count", 32'(dut.u_fifo.count_q), 32'(W * H / 4));
    check("resume_sync_err", 32'(sync_err), 32'd0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/video_in_pack.md
VIDEO_IN_PACK -- requirements
Module: video_in_pack

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- P_WIDTH, 640, active pixels per line (multiple of 4).
- P_HEIGHT, 480, active lines per frame.
- FIFO_DEPTH, 64, 32-bit words held (power of 2).
- NB_PACK, 16, word threshold for a burst toward the store stage.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock for all logic.
- nRST, in, 1, reset; asynchronous, active-low.
- frame_valid, in, 1, camera frame envelope.
- line_valid, in, 1, camera line envelope; pixel qualifier.
- pixel_in, in, 8, greyscale pixel.
- rd_en, in, 1, store stage pops one word.
- data_fifo, out, 32, popped word.
- nb_pack_available, out, 1, at least NB_PACK words stored.
- frame_start, out, 1, one-cycle pulse at accepted frame start.
- overflow, out, 1, sticky: word dropped on full FIFO.
- sync_err, out, 1, sticky: line length not equal to P_WIDTH, or frame line count not equal to P_HEIGHT.

Function
REQ-003 The block SHALL ignore pixels until a frame_valid rising edge is seen after reset; it never captures a partial frame.
REQ-004 FSM states SHALL be WAIT_FRAME, WAIT_LINE, IN_LINE.
- WAIT_FRAME -> WAIT_LINE on frame_valid rise; frame_start pulses that cycle.
- WAIT_LINE -> IN_LINE when line_valid=1; the first pixel is captured that cycle.
- IN_LINE -> WAIT_LINE when line_valid falls.
- WAIT_LINE -> WAIT_FRAME when frame_valid falls.
REQ-005 Each cycle with line_valid=1 in an accepted frame SHALL capture one pixel; pixels pack little-endian: 1st in [7:0], 4th in [31:24].
REQ-006 A 32-bit word SHALL be written to the FIFO in the cycle after its 4th pixel is captured (1-cycle latency).
REQ-007 The pixel column counter SHALL be 10 bits. The line counter SHALL be 9 bits. Both clear on frame_start.
REQ-008 If line_valid falls at a column count not equal to P_WIDTH, or not on a 4-pixel boundary, the partial word SHALL be discarded and sync_err set.
REQ-009 If frame_valid falls at a line count not equal to P_HEIGHT, sync_err SHALL be set.
REQ-010 A write while the FIFO is full and rd_en=0 SHALL drop the word and set overflow; FIFO contents stay unchanged.
REQ-011 A simultaneous write and rd_en while full SHALL succeed; count is unchanged.
REQ-012 rd_en while empty SHALL be ignored; data_fifo holds its value and count stays 0.
REQ-013 data_fifo SHALL be registered and valid the cycle after rd_en (1-cycle read latency).
REQ-014 The word count SHALL be clog2(FIFO_DEPTH)+1 bits, range 0..FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.
REQ-015 nb_pack_available SHALL equal (count >= NB_PACK), decoded from the registered count.
REQ-016 overflow and sync_err SHALL clear only on frame_start or reset.

Reset
REQ-017 On nRST low, the block SHALL asynchronously enter this state:
- FSM = WAIT_FRAME;
- all counters and pointers = 0;
- pack register = 0;
- data_fifo = 0;
- nb_pack_available, frame_start, overflow, sync_err = 0.
REQ-018 Reset mid-line SHALL discard FIFO contents and any partial word; capture resumes only at the next frame_valid rise.

Structure
REQ-019 A shared package video_in_pkg SHALL hold the FSM enum type and the P_WIDTH, P_HEIGHT, NB_PACK defaults; video_in_store uses the same package.
REQ-020 Storage SHALL be one sub-module, video_in_fifo: synchronous 32-bit FIFO with count output and full/empty flags; packing and the FSM stay in video_in_pack.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Pixels 0x01,0x02,0x03,0x04 in one line -> word 0x04030201 written; data_fifo = 0x04030201 one cycle after rd_en.
- Full 640x480 frame, rd_en pulsed whenever nb_pack_available=1 -> 76800 words read, no overflow, no sync_err, exactly one frame_start.
- 64 words written with no reads, then one more word -> count = 64, overflow = 1, the 65th word is absent on readback.
- Full FIFO with write and rd_en in the same cycle -> count stays 64, no overflow, FIFO order preserved.
- Line of 638 pixels -> sync_err = 1, last partial word discarded; sync_err clears on the next frame_start.
- nRST pulsed mid-line, then pixels with frame_valid already high -> nothing written until the next frame_valid rise.
